instr_imm_packer: RTL and testbench
===================================

INSTR_IMM_PACKER -- requirements
Module: instr_imm_packer

Interface
REQ-001 Parameter: START_ADDR, 32'h0000_0000, byte address given to the first packed instruction after reset.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted on an edge where in_valid and in_ready are both 1.
REQ-006 in_immsrc  input  2  format: 00 I, 01 S, 10 B, 11 pass-through.
REQ-007 in_base  input  32  instruction with opcode/funct/register fields set; immediate field bits are don't-care.
REQ-008 in_imm  input  32  signed immediate in two's complement; B-format value is the byte offset.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  head entry consumed on an edge where out_valid and out_ready are both 1.
REQ-011 out_instr  output  32  packed instruction of the head entry.
REQ-012 out_addr  output  32  byte address of the head entry.
REQ-013 err_count  output  8  count of rejected requests, saturating.

Function
REQ-014 Packing: I: [31:20]=imm[11:0]; S: [31:25]=imm[11:5], [11:7]=imm[4:0]; B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; all other bits come from in_base; format 11 passes in_base unchanged.
REQ-015 Output storage: 2-entry FIFO of {instr, addr}, ordered strictly by acceptance.
REQ-016 in_ready = 1 when FIFO count < 2; it depends only on registered state and has no combinational path from out_ready.
REQ-017 Latency: a request accepted at edge N drives out_valid=1 from edge N when the FIFO was empty before edge N.
REQ-018 Simultaneous push and pop: the count is unchanged and order is preserved.
REQ-019 Full (count 2): the request is held and not accepted; a pop at edge N raises in_ready after edge N.
REQ-020 Address counter: 32-bit, value START_ADDR at reset; each FIFO push assigns the current value to that entry, then adds 4, wrapping modulo 2^32.
REQ-021 The address counter does not advance for dropped requests.
REQ-022 out_instr and out_addr are 0 while out_valid=0.
REQ-023 err_count saturates at 255.

Reset
REQ-024 While reset=1 at an edge: FIFO is empty, out_valid=0, in_ready=1, out_instr=0, out_addr=0, address counter=START_ADDR, err_count=0.
REQ-025 Reset mid-operation discards all buffered entries and any in-flight request, and no handshake completes on that edge.
REQ-026 Reset has priority over push, pop and error events.

Configuration
REQ-027 Macro IMM_RANGE_CHECK_EN, defined: legal ranges are I/S -2048..2047 and B -4096..4094 with imm[0]=0; format 11 is never checked.
REQ-028 With IMM_RANGE_CHECK_EN defined, an illegal request is accepted (in_ready unchanged), not pushed, and increments err_count.
REQ-029 Macro IMM_RANGE_CHECK_EN, undefined: the immediate is truncated per REQ-014, every accepted request is pushed, and err_count is constant 0.

Verification
REQ-030 I-format: base 0x00000013, imm 0xFFFFFFFF -> out_instr 0xFFF00013, out_addr 0x0.
REQ-031 S-format: base 0x00002023, imm 8 -> out_instr 0x00002423; B-format: base 0x00000063, imm -4 -> out_instr 0xFE000EE3, out_addr 0x4.
REQ-032 IMM_RANGE_CHECK_EN defined: B-format imm 3 then I-format imm 2048 -> no out_valid, err_count 2; next legal request -> out_addr START_ADDR.
REQ-033 out_ready=0 with 3 back-to-back requests -> 2 accepted, then in_ready=0; release out_ready -> 3 outputs in order at addresses 0x0, 0x4, 0x8.
REQ-034 FIFO holding 2 entries, err_count 5, then reset for 1 cycle -> out_valid 0, in_ready 1, err_count 0, next push gets address START_ADDR.
REQ-035 Address counter preloaded via START_ADDR=0xFFFFFFFC, 2 pushes -> out_addr 0xFFFFFFFC, then 0x00000000.

Source files
------------

// File: rtl/instr_imm_packer_if.sv
// -----------------------------------------------------------------------------
// instr_imm_packer_if
//
// Purpose:
//   Bundles the request channel (producer -> packer) and the response channel
//   (packer -> consumer) of instr_imm_packer into one interface.
//
// Handshake rule, identical on both channels:
//   A transfer completes on a rising clk edge where valid and ready are both 1.
//   The sender holds valid and its payload stable until that edge; ready may
//   change freely and never depends combinationally on the sender's valid.
//
// Signals:
//   in_valid   producer -> packer  request present
//   in_ready   packer -> producer  packer can take a request this cycle
//   in_immsrc  producer -> packer  format: 00 I, 01 S, 10 B, 11 pass-through
//   in_base    producer -> packer  instruction with immediate bits don't-care
//   in_imm     producer -> packer  signed immediate (B: byte offset)
//   out_valid  packer -> consumer  head FIFO entry valid
//   out_ready  consumer -> packer  head entry consumed
//   out_instr  packer -> consumer  packed instruction of head entry
//   out_addr   packer -> consumer  byte address of head entry
//   err_count  packer -> consumer  saturating count of rejected requests
//
// Modports:
//   master  the side that produces requests and consumes results (testbench)
//   slave   the packer itself
// -----------------------------------------------------------------------------
interface instr_imm_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_immsrc;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [7:0]  err_count;

    modport master (
        output in_valid,
        output in_immsrc,
        output in_base,
        output in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_addr,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_immsrc,
        input  in_base,
        input  in_imm,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_addr,
        output err_count
    );
endinterface

// File: rtl/instr_imm_packer.sv
// -----------------------------------------------------------------------------
// instr_imm_packer
//
// Purpose:
//   Inserts a signed immediate into the immediate fields of a RISC-V style
//   instruction word (I, S or B layout, or pass-through), tags the result with
//   a running byte address, and queues {instr, addr} in a 2-entry FIFO.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  synchronous, active-high; clears FIFO, address counter, err_count
//   bus    instr_imm_packer_if.slave (request + response channels, see the
//          interface file for the valid/ready rule)
//
// Parameters:
//   START_ADDR  byte address given to the first packed instruction after reset
//
// Configuration macro:
//   IMM_RANGE_CHECK_EN
//     undefined (default): immediates are silently truncated to the field
//       width, every accepted request is pushed, err_count is tied to 0.
//     defined: I/S immediates must lie in -2048..2047, B immediates in
//       -4096..4094 and be even; pass-through is never checked. An illegal
//       request is still accepted (handshake completes) but is dropped,
//       does not consume an address and bumps the saturating err_count.
// -----------------------------------------------------------------------------
module instr_imm_packer #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_imm_packer_if.slave     bus
);

    // -------------------------------------------------------------------------
    // Format encodings
    // -------------------------------------------------------------------------
    localparam logic [1:0] FMT_I    = 2'b00;
    localparam logic [1:0] FMT_S    = 2'b01;
    localparam logic [1:0] FMT_B    = 2'b10;

    // -------------------------------------------------------------------------
    // FIFO storage and control state
    // -------------------------------------------------------------------------
    logic [31:0] r_mem_instr [2];
    logic [31:0] r_mem_addr  [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [31:0] r_addr;

    logic [31:0] w_pack_instr;
    logic        w_imm_legal;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // -------------------------------------------------------------------------
    // Immediate packing
    // -------------------------------------------------------------------------
    always_comb begin
        w_pack_instr = bus.in_base;
        case (bus.in_immsrc)
            FMT_I: begin
                w_pack_instr = {bus.in_imm[11:0], bus.in_base[19:0]};
            end
            FMT_S: begin
                w_pack_instr = {bus.in_imm[11:5], bus.in_base[24:12],
                                bus.in_imm[4:0], bus.in_base[6:0]};
            end
            FMT_B: begin
                // B immediate is a byte offset; bit 0 is implied zero and
                // bit 11 is folded down into instruction bit 7.
                w_pack_instr = {bus.in_imm[12], bus.in_imm[10:5],
                                bus.in_base[24:12],
                                bus.in_imm[4:1], bus.in_imm[11],
                                bus.in_base[6:0]};
            end
            default: begin
                w_pack_instr = bus.in_base;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Immediate range check (optional)
    // -------------------------------------------------------------------------
`ifdef IMM_RANGE_CHECK_EN
    logic       w_err;
    logic [7:0] r_err_count;

    // A value fits an N-bit signed field when every bit from N-1 upward is a
    // copy of the sign bit, i.e. the top slice is all-zeros or all-ones.
    always_comb begin
        w_imm_legal = 1'b1;
        case (bus.in_immsrc)
            FMT_I, FMT_S: begin
                w_imm_legal = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
            end
            FMT_B: begin
                w_imm_legal = ((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12]))
                              & ~bus.in_imm[0];
            end
            default: begin
                w_imm_legal = 1'b1;
            end
        endcase
    end

    assign w_err = w_accept & ~w_imm_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= 8'd0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    // Without checking, bits above the widest field (B uses imm[12:1]) are
    // simply discarded.
    logic w_unused_imm_bits;
    assign w_unused_imm_bits = ^bus.in_imm[31:13];

    assign w_imm_legal   = 1'b1;
    assign bus.err_count = 8'd0;
`endif

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // in_ready is a function of the registered count only, so a pop on this
    // edge cannot open a slot for a push on the same edge when full.
    assign w_in_ready  = (r_count < 2'd2);
    assign w_out_valid = (r_count != 2'd0);

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_push   = w_accept & w_imm_legal;
    assign w_pop    = w_out_valid & bus.out_ready;

    // -------------------------------------------------------------------------
    // FIFO and address counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= 2'd0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_addr         <= START_ADDR;
            r_mem_instr[0] <= 32'd0;
            r_mem_instr[1] <= 32'd0;
            r_mem_addr[0]  <= 32'd0;
            r_mem_addr[1]  <= 32'd0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_pack_instr;
                r_mem_addr[r_wr_ptr]  <= r_addr;
                r_wr_ptr              <= ~r_wr_ptr;
                // Wraps naturally modulo 2^32.
                r_addr                <= r_addr + 32'd4;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: payload is forced to zero whenever the FIFO is empty
    // -------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign bus.out_addr  = w_out_valid ? r_mem_addr[r_rd_ptr]  : 32'd0;

endmodule

// File: tb/tb_instr_imm_packer.sv
// -----------------------------------------------------------------------------
// tb_instr_imm_packer
//
// Self-checking bench for instr_imm_packer. A queue-based reference model
// tracks the expected FIFO contents, address counter and error count; each
// test task drives stimulus through tick() and checks the DUT inline.
// A second instance built with START_ADDR = 0xFFFFFFFC covers address wrap.
// Works with or without IMM_RANGE_CHECK_EN defined.
// -----------------------------------------------------------------------------
module tb_instr_imm_packer;

    localparam logic [31:0] START      = 32'h0000_0000;
    localparam logic [31:0] WRAP_START = 32'hFFFF_FFFC;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_imm_packer_if bus ();
    instr_imm_packer_if bus_w ();

    instr_imm_packer #(.START_ADDR(START)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_imm_packer #(.START_ADDR(WRAP_START)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    // -------------------------------------------------------------------------
    // Reference model state and scoreboard
    // -------------------------------------------------------------------------
    logic [63:0] exp_q[$];      // {instr, addr}
    logic [31:0] m_addr;
    int          m_err;
    int          n_cmp;
    int          n_fail;

    // Clear the immediate bit positions with a mask, then OR in shifted fields.
    function automatic logic [31:0] model_pack(input logic [1:0] src,
                                               input logic [31:0] base,
                                               input logic [31:0] imm);
        case (src)
            2'd0: return (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
            2'd1: return (base & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25)
                         | ((imm & 32'h1F) << 7);
            2'd2: return (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31)
                         | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'h1) << 7);
            default: return base;
        endcase
    endfunction

    function automatic bit model_legal(input logic [1:0] src, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if (!CHECK_ON) return 1'b1;
        case (src)
            2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
            2'd2:       return (s >= -4096) && (s <= 4094) && ((s % 2) == 0);
            default:    return 1'b1;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Driver: apply inputs at negedge, update model, advance one full cycle
    // -------------------------------------------------------------------------
    task automatic tick(input logic v, input logic [1:0] src, input logic [31:0] base,
                        input logic [31:0] imm, input logic ordy, input logic rst);
        bit do_pop;
        bit do_acc;
        bus.in_valid  = v;
        bus.in_immsrc = src;
        bus.in_base   = base;
        bus.in_imm    = imm;
        bus.out_ready = ordy;
        reset         = rst;
        if (rst) begin
            exp_q.delete();
            m_addr = START;
            m_err  = 0;
        end else begin
            do_pop = (exp_q.size() != 0) && ordy;
            do_acc = v && (exp_q.size() < 2);
            if (do_pop) void'(exp_q.pop_front());
            if (do_acc) begin
                if (model_legal(src, imm)) begin
                    exp_q.push_back({model_pack(src, base, imm), m_addr});
                    m_addr = m_addr + 32'd4;
                end else if (m_err < 255) begin
                    m_err = m_err + 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
        n_cmp++; if (bus.out_addr !== 32'd0) begin n_fail++; $display("FAIL reset_out_addr got %h want 0", bus.out_addr); end
        n_cmp++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
        n_cmp++; if (bus_w.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wrap_out_valid got %0b want 0", bus_w.out_valid); end
        tick(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_addr_wrap();
        bus_w.in_valid  = 1'b1;
        bus_w.in_immsrc = 2'd3;
        bus_w.in_base   = 32'h1111_1111;
        bus_w.in_imm    = 32'd0;
        bus_w.out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        bus_w.in_base   = 32'h2222_2222;
        @(posedge clk); @(negedge clk);
        bus_w.in_valid  = 1'b0;
        n_cmp++; if (bus_w.in_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_full_in_ready got %0b want 0", bus_w.in_ready); end
        n_cmp++; if (bus_w.out_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", bus_w.out_addr); end
        n_cmp++; if (bus_w.out_instr !== 32'h1111_1111) begin n_fail++; $display("FAIL wrap_instr0 got %h want 11111111", bus_w.out_instr); end
        bus_w.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_w.out_ready = 1'b0;
        n_cmp++; if (bus_w.out_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr1 got %h want 00000000", bus_w.out_addr); end
        n_cmp++; if (bus_w.out_instr !== 32'h2222_2222) begin n_fail++; $display("FAIL wrap_instr1 got %h want 22222222", bus_w.out_instr); end
    endtask

    task automatic test_vectors();
        do_reset();
        tick(1'b1, 2'd0, 32'h0000_0013, 32'hFFFF_FFFF, 1'b0, 1'b0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL vec_i_latency got %0b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_instr !== 32'hFFF0_0013) begin n_fail++; $display("FAIL vec_i_instr got %h want fff00013", bus.out_instr); end
        n_cmp++; if (bus.out_addr !== 32'h0) begin n_fail++; $display("FAIL vec_i_addr got %h want 0", bus.out_addr); end
        do_reset();
        tick(1'b1, 2'd1, 32'h0000_2023, 32'd8, 1'b0, 1'b0);
        n_cmp++; if (bus.out_instr !== 32'h0000_2423) begin n_fail++; $display("FAIL vec_s_instr got %h want 00002423", bus.out_instr); end
        tick(1'b1, 2'd2, 32'h0000_0063, 32'hFFFF_FFFC, 1'b1, 1'b0);
        n_cmp++; if (bus.out_instr !== 32'hFE00_0EE3) begin n_fail++; $display("FAIL vec_b_instr got %h want fe000ee3", bus.out_instr); end
        n_cmp++; if (bus.out_addr !== 32'h4) begin n_fail++; $display("FAIL vec_b_addr got %h want 4", bus.out_addr); end
        drain();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_empty_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if ({bus.out_instr, bus.out_addr} !== 64'd0) begin n_fail++; $display("FAIL vec_empty_zero got %h/%h want 0/0", bus.out_instr, bus.out_addr); end
    endtask

    task automatic test_range();
        do_reset();
        tick(1'b1, 2'd2, 32'h0000_0063, 32'd3, 1'b1, 1'b0);
        tick(1'b1, 2'd0, 32'h0000_0013, 32'd2048, 1'b1, 1'b0);
        n_cmp++; if (bus.out_valid !== !CHECK_ON) begin n_fail++; $display("FAIL range_out_valid got %0b want %0b", bus.out_valid, !CHECK_ON); end
        n_cmp++; if (bus.err_count !== (CHECK_ON ? 8'd2 : 8'd0)) begin n_fail++; $display("FAIL range_err_count got %0d want %0d", bus.err_count, CHECK_ON ? 2 : 0); end
        tick(1'b1, 2'd0, 32'h0000_0013, 32'd5, 1'b1, 1'b0);
        n_cmp++; if (bus.out_addr !== (CHECK_ON ? START : START + 32'd8)) begin n_fail++; $display("FAIL range_next_addr got %h want %h", bus.out_addr, CHECK_ON ? START : START + 32'd8); end
        n_cmp++; if (bus.out_instr !== 32'h0050_0013) begin n_fail++; $display("FAIL range_next_instr got %h want 00500013", bus.out_instr); end
        drain();
    endtask

    task automatic test_back_to_back();
        int          sent;
        int          n_got;
        bit          acc;
        logic [31:0] got_addr [3];
        logic [31:0] got_instr [3];
        do_reset();
        sent = 0;
        for (int i = 0; i < 3; i++) begin
            acc = (exp_q.size() < 2);
            tick(1'b1, 2'd3, 32'hA000_0000 + 32'(sent), 32'd0, 1'b0, 1'b0);
            if (acc) sent++;
        end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_in_ready got %0b want 0", bus.in_ready); end
        n_cmp++; if (sent !== 2) begin n_fail++; $display("FAIL b2b_accepted got %0d want 2", sent); end
        n_got = 0;
        for (int c = 0; c < 10 && n_got < 3; c++) begin
            if (bus.out_valid === 1'b1) begin
                got_addr[n_got]  = bus.out_addr;
                got_instr[n_got] = bus.out_instr;
                n_got++;
            end
            acc = (sent < 3) && (exp_q.size() < 2);
            tick(sent < 3, 2'd3, 32'hA000_0000 + 32'(sent), 32'd0, 1'b1, 1'b0);
            if (acc) sent++;
        end
        n_cmp++; if (n_got !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3 (cycle budget)", n_got); end
        for (int i = 0; i < n_got; i++) begin
            n_cmp++; if (got_addr[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h want %h", i, got_addr[i], 32'(4 * i)); end
            n_cmp++; if (got_instr[i] !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL b2b_instr[%0d] got %h want %h", i, got_instr[i], 32'hA000_0000 + 32'(i)); end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < (CHECK_ON ? 5 : 0); i++) tick(1'b1, 2'd0, 32'h13, 32'd4000, 1'b0, 1'b0);
        tick(1'b1, 2'd0, 32'h13, 32'd1, 1'b0, 1'b0);
        tick(1'b1, 2'd0, 32'h13, 32'd2, 1'b0, 1'b0);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_in_ready got %0b want 0", bus.in_ready); end
        n_cmp++; if (bus.err_count !== 8'(m_err)) begin n_fail++; $display("FAIL mid_err_before got %0d want %0d", bus.err_count, m_err); end
        tick(1'b1, 2'd0, 32'h13, 32'd7, 1'b1, 1'b1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL mid_rst_err got %0d want 0", bus.err_count); end
        tick(1'b1, 2'd0, 32'h13, 32'd7, 1'b0, 1'b0);
        n_cmp++; if (bus.out_addr !== START) begin n_fail++; $display("FAIL mid_next_addr got %h want %h", bus.out_addr, START); end
        n_cmp++; if (bus.out_instr !== 32'h0070_0013) begin n_fail++; $display("FAIL mid_next_instr got %h want 00700013", bus.out_instr); end
        drain();
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) tick(1'b1, 2'd1, 32'h2023, 32'hFFFF_0000, 1'b1, 1'b0);
        n_cmp++; if (bus.err_count !== (CHECK_ON ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL err_saturate got %0d want %0d", bus.err_count, CHECK_ON ? 255 : 0); end
        drain();
    endtask

    task automatic test_random();
        int          edge_vals [8] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098};
        logic [31:0] imm;
        logic [63:0] head;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (bus.out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %0b want %0b", c, bus.out_valid, exp_q.size() != 0); end
            n_cmp++; if (bus.in_ready !== (exp_q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", c, bus.in_ready, exp_q.size() < 2); end
            n_cmp++; if (bus.err_count !== 8'(m_err)) begin n_fail++; $display("FAIL rnd_err cyc %0d got %0d want %0d", c, bus.err_count, m_err); end
            head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
            n_cmp++; if ({bus.out_instr, bus.out_addr} !== head) begin n_fail++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", c, bus.out_instr, bus.out_addr, head[63:32], head[31:0]); end
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = edge_vals[$urandom_range(0, 7)];
                default: imm = 32'($urandom_range(0, 63));
            endcase
            tick($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, imm,
                 $urandom_range(0, 1) == 1, 1'b0);
        end
        drain();
    endtask

    // -------------------------------------------------------------------------
    // Sequencer and report
    // -------------------------------------------------------------------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_addr = START;
        m_err  = 0;
        bus.in_valid    = 1'b0;
        bus.in_immsrc   = 2'd0;
        bus.in_base     = 32'd0;
        bus.in_imm      = 32'd0;
        bus.out_ready   = 1'b0;
        bus_w.in_valid  = 1'b0;
        bus_w.in_immsrc = 2'd0;
        bus_w.in_base   = 32'd0;
        bus_w.in_imm    = 32'd0;
        bus_w.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_addr_wrap();
        test_vectors();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_err_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
